mem_seg: RTL and testbench
==========================

MEM_SEG -- requirements
Module: mem_seg

Interface
- REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, giving a data RAM of 2^DEPTH_LOG2 32-bit words.
- REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
- REQ-004 The block SHALL have port validi, input, 1 bit: the EX-stage outputs are a real instruction this cycle.
- REQ-005 The block SHALL have port IRi, input, 32 bits: the instruction from the EX stage.
- REQ-006 The block SHALL have port ALUi, input, 32 bits: the EX result (effective address, branch target or ALU result).
- REQ-007 The block SHALL have port Bi, input, 32 bits: store data from the EX stage.
- REQ-008 The block SHALL have port condi, input, 1 bit: the EX branch condition.
- REQ-009 The block SHALL have port valido, output, 1 bit: the WB-bound outputs are valid.
- REQ-010 The block SHALL have port IRo, output, 32 bits: the registered instruction.
- REQ-011 The block SHALL have port ALUo, output, 32 bits: the registered ALUi.
- REQ-012 The block SHALL have port LMDo, output, 32 bits: the registered load data.
- REQ-013 The block SHALL have port PCsel, output, 1 bit: the registered redirect request to IF.
- REQ-014 The block SHALL have port PCtgt, output, 32 bits: the registered redirect target.
- REQ-015 The block SHALL have port misalign, output, 1 bit: the registered misaligned-access flag; it exists only with MEM_ALIGN_CHK_EN.

Function
- REQ-016 Decode SHALL use opcode IRi[31:26]:
  - LW = 100011
  - SW = 101011
  - BEQ = 000100
  - BNE = 000101
  - J = 000010
  - all other opcodes are pass-through.
- REQ-017 The word index SHALL be ALUi[DEPTH_LOG2+1:2]; upper address bits are ignored, so addresses wrap modulo the RAM size.
- REQ-018 RAM read SHALL be asynchronous on the word index, and RAM write SHALL be synchronous on the clk edge.
- REQ-019 On SW with validi=1, RAM[index] SHALL become Bi at the edge.
- REQ-020 On SW with validi=0, RAM SHALL be unchanged.
- REQ-021 On LW with validi=1, LMDo SHALL become RAM[index] at the edge, giving 1-cycle latency.
- REQ-022 On any other instruction, LMDo SHALL hold its previous value.
- REQ-023 A store followed by a load to the same index in the next cycle SHALL return the stored value.
- REQ-024 IRo, ALUo and valido SHALL register IRi, ALUi and validi every cycle; validi=0 SHALL force IRo to 0 (NOP).
- REQ-025 PCsel SHALL be 1 for exactly one cycle after an edge where validi=1 and either (BEQ or BNE with condi=1) or J; otherwise PCsel SHALL be 0.
- REQ-026 PCtgt SHALL register ALUi whenever PCsel is set, and SHALL hold its value otherwise.
- REQ-027 Back-to-back redirects SHALL each produce a one-cycle PCsel pulse with no merging.

Reset
- REQ-028 While rst=0, the following outputs SHALL be 0: valido, IRo, ALUo, LMDo, PCsel, PCtgt, misalign.
- REQ-029 Reset asserted mid-operation SHALL abort any in-flight store, so no RAM write occurs at an edge while rst=0.
- REQ-030 RAM contents SHALL NOT be reset.
- REQ-031 After rst rises, the first rising edge SHALL behave as normal operation.

Configuration
- REQ-032 Macro MEM_ALIGN_CHK_EN defined: for LW or SW with validi=1 and ALUi[1:0] != 0, misalign SHALL be 1 for one cycle, a SW SHALL be suppressed, and LMDo SHALL be held.
- REQ-033 Macro MEM_ALIGN_CHK_EN undefined: the misalign port SHALL be absent, and ALUi[1:0] SHALL be ignored (access rounds down to the word).

Structure
- REQ-034 The opcode constants (LW, SW, BEQ, BNE, J) SHALL live in the shared pipeline package, used by IF, ID, EX, MEM and WB.
- REQ-035 The data RAM SHALL be one sub-module, data_ram (parameter DEPTH_LOG2; ports clk, we, addr, wdata, rdata); all other logic SHALL stay in mem_seg.

Verification
- REQ-036 Reset scenario: drive rst=0 mid-stream with SW pending -> all outputs are 0 and the RAM at the target index is unchanged.
- REQ-037 Store/load scenario: SW with ALUi=0x10, Bi=0xDEADBEEF, then LW with ALUi=0x10 on the next cycle -> one cycle later LMDo=0xDEADBEEF, valido=1.
- REQ-038 Wrap scenario (DEPTH_LOG2=8): SW with ALUi=0x404, Bi=5, then LW with ALUi=0x004 -> LMDo=5.
- REQ-039 Branch scenario: BEQ with condi=1, ALUi=0x80 -> PCsel=1 for one cycle, PCtgt=0x80; BNE with condi=0 -> PCsel stays 0.
- REQ-040 Invalid-input scenario: validi=0 with a SW opcode, Bi=7 -> RAM unchanged, IRo=0, valido=0.
- REQ-041 Alignment scenario (MEM_ALIGN_CHK_EN defined): SW with ALUi=0x11 -> misalign=1 for one cycle and no RAM write; with the macro undefined, word 4 is written.

Source files
------------

// File: rtl/mem_seg_pkg.sv
// ---------------------------------------------------------------------------
// mem_seg_pkg : shared pipeline opcodes and MEM-stage decode helper
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_seg_pkg;

  localparam int unsigned OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_LW  = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW  = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J   = 6'b000010;

  // What the MEM stage needs to know about an instruction; BEQ and BNE
  // collapse to one class because the EX stage already resolved the sense.
  typedef enum logic [2:0] {
    INS_OTHER  = 3'd0,
    INS_LOAD   = 3'd1,
    INS_STORE  = 3'd2,
    INS_BRANCH = 3'd3,
    INS_JUMP   = 3'd4
  } ins_kind_e;

  function automatic ins_kind_e decode_op(input logic [OPCODE_W-1:0] op);
    ins_kind_e kind;
    case (op)
      OP_LW:          kind = INS_LOAD;
      OP_SW:          kind = INS_STORE;
      OP_BEQ, OP_BNE: kind = INS_BRANCH;
      OP_J:           kind = INS_JUMP;
      default:        kind = INS_OTHER;
    endcase
    return kind;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram.sv
// ---------------------------------------------------------------------------
// data_ram : 32-bit data memory, asynchronous read, synchronous write
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_ram #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  // Contents are deliberately not reset.
  logic [31:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

`default_nettype wire

// File: rtl/mem_seg.sv
// ---------------------------------------------------------------------------
// mem_seg  : pipeline MEM stage - data memory access and PC redirect
// Revision : 1.0   Option macro: MEM_ALIGN_CHK_EN (misaligned LW/SW trap)
// ---------------------------------------------------------------------------
`default_nettype none

module mem_seg
  import mem_seg_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validi,
  input  logic [31:0] IRi,
  input  logic [31:0] ALUi,
  input  logic [31:0] Bi,
  input  logic        condi,
  output logic        valido,
  output logic [31:0] IRo,
  output logic [31:0] ALUo,
  output logic [31:0] LMDo,
  output logic        PCsel,
  output logic [31:0] PCtgt
`ifdef MEM_ALIGN_CHK_EN
  ,
  output logic        misalign
`endif
);

  ins_kind_e             kind;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  mis_d;
  logic                  ram_we;
  logic [31:0]           ram_rdata;

  logic        valid_d, valid_q;
  logic [31:0] ir_d,    ir_q;
  logic [31:0] alu_d,   alu_q;
  logic [31:0] lmd_d,   lmd_q;
  logic        pcsel_d, pcsel_q;
  logic [31:0] pctgt_d, pctgt_q;

  assign kind     = decode_op(IRi[31:26]);
  assign word_idx = ALUi[DEPTH_LOG2+1:2];

`ifdef MEM_ALIGN_CHK_EN
  assign mis_d = validi && (kind == INS_LOAD || kind == INS_STORE) &&
                 (ALUi[1:0] != 2'b00);
`else
  assign mis_d = 1'b0;
`endif

  // Gating with rst keeps an in-flight store from landing while in reset.
  assign ram_we = validi && (kind == INS_STORE) && !mis_d && rst;

  data_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_data_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (word_idx),
    .wdata (Bi),
    .rdata (ram_rdata)
  );

  always_comb begin
    valid_d = validi;
    ir_d    = validi ? IRi : 32'h0;
    alu_d   = ALUi;
    lmd_d   = lmd_q;
    pcsel_d = validi && ((kind == INS_JUMP) || (kind == INS_BRANCH && condi));
    pctgt_d = pctgt_q;
    if (validi && kind == INS_LOAD && !mis_d) begin
      lmd_d = ram_rdata;
    end
    if (pcsel_d) begin
      pctgt_d = ALUi;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ir_q    <= 32'h0;
      alu_q   <= 32'h0;
      lmd_q   <= 32'h0;
      pcsel_q <= 1'b0;
      pctgt_q <= 32'h0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      lmd_q   <= lmd_d;
      pcsel_q <= pcsel_d;
      pctgt_q <= pctgt_d;
    end
  end

`ifdef MEM_ALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= mis_d;
    end
  end

  assign misalign = misalign_q;
`endif

  assign valido = valid_q;
  assign IRo    = ir_q;
  assign ALUo   = alu_q;
  assign LMDo   = lmd_q;
  assign PCsel  = pcsel_q;
  assign PCtgt  = pctgt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_seg.sv
// ---------------------------------------------------------------------------
// tb_mem_seg : randomized bench for mem_seg against a behavioural model
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_seg;

  localparam int DL    = 8;
  localparam int WORDS = 1 << DL;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] JMP = 6'b000010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        validi = 1'b0;
  logic        condi = 1'b0;
  logic [31:0] IRi = 32'h0;
  logic [31:0] ALUi = 32'h0;
  logic [31:0] Bi = 32'h0;

  logic        valido;
  logic [31:0] IRo;
  logic [31:0] ALUo;
  logic [31:0] LMDo;
  logic        PCsel;
  logic [31:0] PCtgt;
`ifdef MEM_ALIGN_CHK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  mem_seg #(
    .DEPTH_LOG2 (DL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .validi   (validi),
    .IRi      (IRi),
    .ALUi     (ALUi),
    .Bi       (Bi),
    .condi    (condi),
    .valido   (valido),
    .IRo      (IRo),
    .ALUo     (ALUo),
    .LMDo     (LMDo),
    .PCsel    (PCsel),
    .PCtgt    (PCtgt)
`ifdef MEM_ALIGN_CHK_EN
    ,
    .misalign (misalign)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: memory as a plain array, outputs as the values
  // the rules say must appear after each edge.
  logic [31:0] mem_m [WORDS];
  logic        e_valid = 1'b0;
  logic [31:0] e_ir = 32'h0;
  logic [31:0] e_alu = 32'h0;
  logic [31:0] e_lmd = 32'h0;
  logic        e_pcsel = 1'b0;
  logic [31:0] e_tgt = 32'h0;
  logic        e_mis = 1'b0;
  logic [5:0]  m_op;
  int          m_idx;
  logic        m_bad;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_valid = 1'b0; e_ir = 32'h0; e_alu = 32'h0; e_lmd = 32'h0;
      e_pcsel = 1'b0; e_tgt = 32'h0; e_mis = 1'b0;
    end else begin
      m_op  = IRi[31:26];
      m_idx = int'((ALUi >> 2) % WORDS);
      m_bad = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
      m_bad = validi && (m_op == LW || m_op == SW) && (ALUi % 4 != 0);
`endif
      if (validi && m_op == LW && !m_bad) e_lmd = mem_m[m_idx];
      if (validi && m_op == SW && !m_bad) mem_m[m_idx] = Bi;
      e_pcsel = validi && (m_op == JMP || ((m_op == BEQ || m_op == BNE) && condi));
      if (e_pcsel) e_tgt = ALUi;
      e_ir    = validi ? IRi : 32'h0;
      e_alu   = ALUi;
      e_valid = validi;
      e_mis   = m_bad;
    end
  end

  always @(negedge clk) begin
    check("valido", {31'h0, valido}, {31'h0, e_valid});
    check("IRo",    IRo,   e_ir);
    check("ALUo",   ALUo,  e_alu);
    check("LMDo",   LMDo,  e_lmd);
    check("PCsel",  {31'h0, PCsel}, {31'h0, e_pcsel});
    check("PCtgt",  PCtgt, e_tgt);
`ifdef MEM_ALIGN_CHK_EN
    check("misalign", {31'h0, misalign}, {31'h0, e_mis});
`endif
  end

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] b, input logic c);
    logic [31:0] r;
    r      = $urandom;
    validi = v;
    IRi    = {op, r[25:0]};
    ALUi   = alu;
    Bi     = b;
    condi  = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] alu;
    logic [5:0]  op;

    drive(1'b1, SW, 32'h0000_0010, 32'h1111_1111, 1'b0);
    repeat (3) tick();
    check("rst_valido", {31'h0, valido}, 32'h0);
    check("rst_IRo",    IRo,   32'h0);
    check("rst_ALUo",   ALUo,  32'h0);
    check("rst_PCtgt",  PCtgt, 32'h0);

    rst = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      drive(1'b1, SW, i << 2, $urandom, 1'b0);
      tick();
    end

    // Store then load to the same word on consecutive cycles.
    drive(1'b1, SW, 32'h10, 32'hDEAD_BEEF, 1'b0); tick();
    drive(1'b1, LW, 32'h10, 32'h0, 1'b0);         tick();
    check("st_ld_LMDo",   LMDo, 32'hDEAD_BEEF);
    check("st_ld_valido", {31'h0, valido}, 32'h1);

    // Reset on top of a pending store: outputs clear, word untouched.
    drive(1'b1, SW, 32'h10, 32'h1234_5678, 1'b0);
    rst = 1'b0;
    tick();
    check("midrst_valido", {31'h0, valido}, 32'h0);
    check("midrst_LMDo",   LMDo, 32'h0);
    check("midrst_PCsel",  {31'h0, PCsel}, 32'h0);
    rst = 1'b1;
    drive(1'b1, LW, 32'h10, 32'h0, 1'b0); tick();
    check("midrst_ram", LMDo, 32'hDEAD_BEEF);

    // Address wrap modulo the RAM size.
    drive(1'b1, SW, 32'h404, 32'h5, 1'b0); tick();
    drive(1'b1, LW, 32'h004, 32'h0, 1'b0); tick();
    check("wrap_LMDo", LMDo, 32'h5);

    // Redirects, including back-to-back pulses.
    drive(1'b1, BEQ, 32'h80, 32'h0, 1'b1); tick();
    check("beq_PCsel", {31'h0, PCsel}, 32'h1);
    check("beq_PCtgt", PCtgt, 32'h80);
    drive(1'b1, BNE, 32'h44, 32'h0, 1'b0); tick();
    check("bne0_PCsel", {31'h0, PCsel}, 32'h0);
    check("bne0_PCtgt", PCtgt, 32'h80);
    drive(1'b1, JMP, 32'h100, 32'h0, 1'b0); tick();
    check("j_PCtgt", PCtgt, 32'h100);
    drive(1'b1, BNE, 32'h200, 32'h0, 1'b1); tick();
    check("b2b_PCsel", {31'h0, PCsel}, 32'h1);
    check("b2b_PCtgt", PCtgt, 32'h200);
    drive(1'b1, 6'b001000, 32'h300, 32'h0, 1'b1); tick();
    check("b2b_end_PCsel", {31'h0, PCsel}, 32'h0);

    // Invalid slot carrying a store must not write.
    drive(1'b1, SW, 32'h20, 32'hCAFE_0001, 1'b0); tick();
    drive(1'b0, SW, 32'h20, 32'h7, 1'b0);         tick();
    check("inv_IRo",    IRo, 32'h0);
    check("inv_valido", {31'h0, valido}, 32'h0);
    drive(1'b1, LW, 32'h20, 32'h0, 1'b0);         tick();
    check("inv_ram", LMDo, 32'hCAFE_0001);

    // Misaligned store and load.
    drive(1'b1, SW, 32'h11, 32'hA5A5_A5A5, 1'b0); tick();
`ifdef MEM_ALIGN_CHK_EN
    check("mis_sw_flag", {31'h0, misalign}, 32'h1);
`endif
    drive(1'b1, LW, 32'h10, 32'h0, 1'b0); tick();
`ifdef MEM_ALIGN_CHK_EN
    check("mis_sw_ram",  LMDo, 32'hDEAD_BEEF);
    check("mis_sw_once", {31'h0, misalign}, 32'h0);
`else
    check("mis_sw_ram",  LMDo, 32'hA5A5_A5A5);
`endif
    drive(1'b1, SW, 32'h14, 32'h0BAD_F00D, 1'b0); tick();
    drive(1'b1, LW, 32'h17, 32'h0, 1'b0);         tick();
`ifdef MEM_ALIGN_CHK_EN
    check("mis_lw_hold", LMDo, 32'hDEAD_BEEF);
`else
    check("mis_lw_round", LMDo, 32'h0BAD_F00D);
`endif

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      case ($urandom_range(0, 6))
        0:       op = LW;
        1:       op = SW;
        2:       op = BEQ;
        3:       op = BNE;
        4:       op = JMP;
        default: op = 6'($urandom);
      endcase
      drive(($urandom_range(0, 4) != 0), op, alu, $urandom, 1'($urandom));
      tick();
    end

    rst = 1'b1;
    drive(1'b0, 6'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
